sequenciador_pc: RTL
====================

SEQUENCIADOR_PC -- requirements
Module: sequenciador_pc

Interface
REQ-001 Parameter ADDR_W, default 26: program-counter and target address width.
REQ-002 Parameter RAS_DEPTH, default 8: return-address-stack entries, power of two, at least 2.
REQ-003 Parameter RESET_ADDR, default 0: PC value held during reset.
REQ-004 Parameter INT_VECTOR, default 1: PC loaded on interrupt entry.
REQ-005 clock  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 addOp  input  3  PC operation select: 000 hold, 001 increment, 010 branch, 011 jump, 100 call, 101 return, 110 iret, 111 reserved.
REQ-008 desvio  input  ADDR_W  branch target.
REQ-009 salto  input  ADDR_W  jump/call target.
REQ-010 irq  input  1  level interrupt request.
REQ-011 pcAtual  output  ADDR_W  registered current PC.
REQ-012 emIsr  output  1  high while executing the interrupt handler.
REQ-013 pilhaCheia / pilhaVazia  output  1 each  stack holds RAS_DEPTH / zero entries.
REQ-014 erroOverflow / erroUnderflow  output  1 each  sticky stack error flags.

Function
REQ-015 pcAtual SHALL update once per rising edge; new value visible the cycle after addOp is sampled (1-cycle latency).
REQ-016 Hold SHALL keep pcAtual unchanged; reserved 111 SHALL behave as hold.
REQ-017 Increment SHALL load pcAtual+1 modulo 2^ADDR_W; all-ones wraps to 0.
REQ-018 Branch SHALL load desvio; jump SHALL load salto.
REQ-019 Call SHALL push pcAtual+1 (mod 2^ADDR_W) onto the stack and load salto in the same cycle.
REQ-020 Call with the stack full SHALL overwrite the oldest entry (circular), leave the count at RAS_DEPTH and set erroOverflow.
REQ-021 Return with a non-empty stack SHALL pop and load the top entry.
REQ-022 Return with an empty stack SHALL load pcAtual+1, leave the stack unchanged and set erroUnderflow.
REQ-023 With irq high and emIsr low, interrupt entry SHALL preempt addOp: EPC gets pcAtual (the current instruction is re-executed later), pcAtual gets INT_VECTOR, emIsr is set, and the stack is unchanged.
REQ-024 While emIsr is high, irq SHALL be ignored (no nesting).
REQ-025 Iret with emIsr high SHALL load EPC and clear emIsr; irq is recognised again from the following cycle.
REQ-026 Iret with emIsr low SHALL behave as increment.
REQ-027 Call/return inside the handler SHALL use the same stack normally.
REQ-028 pilhaCheia and pilhaVazia SHALL reflect the registered count, combinationally decoded.
REQ-029 Error flags SHALL stay set until reset.

Reset
REQ-030 Reset low SHALL immediately, regardless of clock, force: pcAtual to RESET_ADDR; EPC, stack pointer, count, emIsr, erroOverflow and erroUnderflow to 0; pilhaVazia to 1 and pilhaCheia to 0.
REQ-031 Reset asserted mid-operation SHALL discard any pending call, return or interrupt effect.
REQ-032 Stack entry storage need not be reset.

Structure
REQ-033 The addOp encodings SHALL be constants in a shared package, pc_pkg.
REQ-034 The return-address stack SHALL be a sub-module, pilha_retorno, parameterised by ADDR_W and RAS_DEPTH, with push/pop/full/empty/top ports and wrap-on-overflow behaviour.
REQ-035 All other state (PC, EPC, emIsr, error flags) SHALL reside in sequenciador_pc.

Verification
REQ-036 Reset release, then addOp=001 for 3 cycles -> pcAtual 0,1,2,3; pcAtual=0x3FFFFFF then increment -> 0.
REQ-037 pc=10, call salto=100; at pc=100 call salto=200; return; return -> pcAtual sequence 100, 200, 101, 11, and pilhaVazia is high at the end.
REQ-038 RAS_DEPTH=8: 9 calls, then 9 returns -> erroOverflow set after the 9th call; the first 8 returns yield the pushed addresses newest first; the 9th return finds the stack empty, yields pc+1 and sets erroUnderflow.
REQ-039 pc=50, irq=1 together with addOp=100 -> next pcAtual=1, emIsr=1, stack unchanged; irq held during the handler has no effect; iret -> pcAtual=50, emIsr=0.
REQ-040 Return with an empty stack at pc=7 -> pcAtual=8 and erroUnderflow=1; iret with emIsr=0 at pc=8 -> pcAtual=9.
REQ-041 Reset asserted asynchronously between edges during a call -> pcAtual=RESET_ADDR immediately, and pilhaVazia=1 after reset releases.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: program-counter operation encodings shared by the sequencer and its bench
package pc_pkg;
  typedef enum logic [2:0] {
    OP_HOLD   = 3'b000,
    OP_INC    = 3'b001,
    OP_BRANCH = 3'b010,
    OP_JUMP   = 3'b011,
    OP_CALL   = 3'b100,
    OP_RET    = 3'b101,
    OP_IRET   = 3'b110,
    OP_RSVD   = 3'b111
  } op_e;
endpackage

// File: rtl/pilha_retorno.sv
// pilha_retorno: circular return-address stack; a push when full overwrites the oldest entry
module pilha_retorno #(
  parameter int ADDR_W    = 26,
  parameter int RAS_DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] top
);
  localparam int PW = $clog2(RAS_DEPTH);
  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]     sp;
  logic [PW:0]       count;
  assign full  = count == (PW+1)'(RAS_DEPTH);
  assign empty = count == '0;
  assign top   = mem[sp - 1'b1];
  // sp wraps naturally, so once full the next write lands on the oldest slot
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      sp    <= '0;
      count <= '0;
    end else if (push) begin
      sp    <= sp + 1'b1;
      count <= full ? count : count + 1'b1;
    end else if (pop && !empty) begin
      sp    <= sp - 1'b1;
      count <= count - 1'b1;
    end
  always_ff @(posedge clock)
    if (push) mem[sp] <= din;
endmodule

// File: rtl/sequenciador_pc.sv
// sequenciador_pc: program counter with call/return stack and single-level interrupt entry
module sequenciador_pc import pc_pkg::*; #(
  parameter int              ADDR_W     = 26,
  parameter int              RAS_DEPTH  = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [ADDR_W-1:0] INT_VECTOR = ADDR_W'(1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        addOp,
  input  logic [ADDR_W-1:0] desvio,
  input  logic [ADDR_W-1:0] salto,
  input  logic              irq,
  output logic [ADDR_W-1:0] pcAtual,
  output logic              emIsr,
  output logic              pilhaCheia,
  output logic              pilhaVazia,
  output logic              erroOverflow,
  output logic              erroUnderflow
);
  logic [ADDR_W-1:0] epc, pc_inc, pc_next, ras_top;
  logic take_irq, push, pop, iret, ret_empty;
  assign take_irq  = irq && !emIsr;
  assign pc_inc    = pcAtual + 1'b1;
  assign push      = !take_irq && addOp == OP_CALL;
  assign pop       = !take_irq && addOp == OP_RET && !pilhaVazia;
  assign ret_empty = !take_irq && addOp == OP_RET && pilhaVazia;
  assign iret      = addOp == OP_IRET && emIsr;
  // interrupt entry outranks every opcode; iret outside the handler degrades to increment
  always_comb
    pc_next = take_irq                                                      ? INT_VECTOR :
              (addOp == OP_INC || ret_empty || (addOp == OP_IRET && !emIsr)) ? pc_inc :
              addOp == OP_BRANCH                                            ? desvio :
              (addOp == OP_JUMP || addOp == OP_CALL)                        ? salto :
              addOp == OP_RET                                               ? ras_top :
              iret                                                          ? epc : pcAtual;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      pcAtual       <= RESET_ADDR;
      epc           <= '0;
      emIsr         <= 1'b0;
      erroOverflow  <= 1'b0;
      erroUnderflow <= 1'b0;
    end else begin
      pcAtual       <= pc_next;
      if (take_irq) epc <= pcAtual;
      emIsr         <= take_irq || (emIsr && !iret);
      erroOverflow  <= erroOverflow || (push && pilhaCheia);
      erroUnderflow <= erroUnderflow || ret_empty;
    end
  pilha_retorno #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) u_pilha (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(pc_inc),
    .full(pilhaCheia),
    .empty(pilhaVazia),
    .top(ras_top)
  );
endmodule
